// File: rtl/quiz_pkg.sv
// Shared quiz types: choice width, FSM state encoding and joystick decode.
// Also the width helper used for the question index.
package quiz_pkg;

    localparam int CW = 3;

    typedef logic [CW-1:0] choice_t;

    typedef enum logic [1:0] {
        ST_RELEASE = 2'd0,
        ST_ASK     = 2'd1,
        ST_RESULT  = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic int max1_clog2(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Exactly one button low selects a choice; anything else is no press.
    function automatic choice_t decode_joy(input logic [3:0] nib);
        case (nib)
            4'b1110: return 3'd1;
            4'b1101: return 3'd2;
            4'b1011: return 3'd3;
            4'b0111: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/quiz_round_ctrl_if.sv
// Player inputs, question ROM handshake and scoreboard outputs of the quiz controller.
// master drives buttons and the answer key; slave is the controller.
interface quiz_round_ctrl_if
    import quiz_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_Q       = 8,
    parameter int SCORE_MAX   = 5
);
    localparam int QW = max1_clog2(NUM_Q);
    localparam int SW = $clog2(SCORE_MAX + 1);

    logic [4*NUM_PLAYERS-1:0]  joy_n;
    logic [CW-1:0]             q_ans;
    logic [QW-1:0]             q_idx;
    logic [SW*NUM_PLAYERS-1:0] score;
    logic [NUM_PLAYERS-1:0]    correct_pulse;
    logic [NUM_PLAYERS-1:0]    lockout;
    logic                      game_over;
    logic [NUM_PLAYERS-1:0]    winner;

    modport master (
        output joy_n, q_ans,
        input  q_idx, score, correct_pulse, lockout, game_over, winner
    );

    modport slave (
        input  joy_n, q_ans,
        output q_idx, score, correct_pulse, lockout, game_over, winner
    );

endinterface

// File: rtl/quiz_joy_decode.sv
// One player's joystick: 2-flop synchronizer, choice decode, press-edge detect.
// Latency: choice valid 2 clocks after joy_n changes; press is combinational on that.
// Backpressure: none, the joystick is sampled every clock.
module quiz_joy_decode
    import quiz_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] joy_n,
    output choice_t    choice,
    output logic       idle,
    output logic       press
);

    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [1:0] vld;
    choice_t    prev;
    logic       armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            vld   <= '0;
            prev  <= '0;
            armed <= 1'b0;
        end else begin
            sync1 <= joy_n;
            sync2 <= sync1;
            vld   <= {vld[0], 1'b1};
            prev  <= choice;
            if (idle) begin
                armed <= 1'b1;
            end
        end
    end

    // Until the synchronizer holds real samples, and until the player has been
    // seen released once after reset, nothing counts as a press.
    assign choice = vld[1] ? decode_joy(sync2) : '0;
    assign idle   = vld[1] && (choice == '0);
    assign press  = armed && (choice != '0) && (prev == '0);

endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz round controller: buzz-in arbitration, scoring, lockout and question sequencing.
// Latency: a press before edge k is scored on edge k+2 (2-flop sync + 1 FSM clock).
// Backpressure: none; presses outside ASK or from locked players are dropped.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_Q       = 8,
    parameter int SCORE_MAX   = 5,
    parameter int HOLD_CYC    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    quiz_round_ctrl_if.slave        bus
);

    localparam int QW = max1_clog2(NUM_Q);
    localparam int SW = $clog2(SCORE_MAX + 1);
    localparam int HW = max1_clog2(HOLD_CYC);
    localparam int IW = $clog2(NUM_PLAYERS);

    choice_t                choice [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] idle_v;
    logic [NUM_PLAYERS-1:0] press_v;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_joy
        quiz_joy_decode u_dec (
            .clk    (clk),
            .rst_n  (rst_n),
            .joy_n  (bus.joy_n[4*p +: 4]),
            .choice (choice[p]),
            .idle   (idle_v[p]),
            .press  (press_v[p])
        );
    end

    state_e                 state;
    logic [SW-1:0]          score_r [NUM_PLAYERS];
    logic [QW-1:0]          q_idx_r;
    logic [NUM_PLAYERS-1:0] lockout_r;
    logic [NUM_PLAYERS-1:0] pulse_r;
    logic [NUM_PLAYERS-1:0] winner_r;
    logic                   game_over_r;
    logic [HW-1:0]          hold_cnt;

    logic [NUM_PLAYERS-1:0] eligible;
    logic [NUM_PLAYERS-1:0] win_oh;
    logic [IW-1:0]          win_idx;
    choice_t                win_choice;
    logic                   any_max;
    logic                   last_q;
    logic [SW-1:0]          max_s;
    logic [NUM_PLAYERS-1:0] max_mask;

    assign eligible = press_v & ~lockout_r;
    assign win_oh   = eligible & (~eligible + NUM_PLAYERS'(1));
    assign last_q   = (q_idx_r == QW'(NUM_Q - 1));

    // Scan downward so the lowest-indexed eligible player is the final pick.
    always_comb begin
        win_idx = '0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (eligible[p]) begin
                win_idx = IW'(p);
            end
        end
        win_choice = choice[win_idx];
    end

    always_comb begin
        any_max = 1'b0;
        max_s   = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (score_r[p] == SW'(SCORE_MAX)) begin
                any_max = 1'b1;
            end
            if (score_r[p] > max_s) begin
                max_s = score_r[p];
            end
        end
        max_mask = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            max_mask[p] = (score_r[p] == max_s);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RELEASE;
            q_idx_r     <= '0;
            lockout_r   <= '0;
            pulse_r     <= '0;
            winner_r    <= '0;
            game_over_r <= 1'b0;
            hold_cnt    <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                score_r[p] <= '0;
            end
        end else begin
            pulse_r <= '0;
            case (state)
                ST_RELEASE: begin
                    if (&idle_v) begin
                        state <= ST_ASK;
                    end
                end
                ST_ASK: begin
                    if (|eligible) begin
                        if (win_choice == bus.q_ans) begin
                            if (score_r[win_idx] != SW'(SCORE_MAX)) begin
                                score_r[win_idx] <= score_r[win_idx] + SW'(1);
                            end
                            pulse_r[win_idx] <= 1'b1;
                            hold_cnt         <= '0;
                            state            <= ST_RESULT;
                        end else begin
                            lockout_r[win_idx] <= 1'b1;
                            if (&(lockout_r | win_oh)) begin
                                hold_cnt <= '0;
                                state    <= ST_RESULT;
                            end
                        end
                    end
                end
                ST_RESULT: begin
                    if (hold_cnt == HW'(HOLD_CYC - 1)) begin
                        if (last_q || any_max) begin
                            winner_r    <= max_mask;
                            game_over_r <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            q_idx_r   <= q_idx_r + QW'(1);
                            lockout_r <= '0;
                            state     <= ST_RELEASE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_RELEASE;
                end
            endcase
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_score
        assign bus.score[p*SW +: SW] = score_r[p];
    end

    assign bus.q_idx         = q_idx_r;
    assign bus.correct_pulse = pulse_r;
    assign bus.lockout       = lockout_r;
    assign bus.game_over     = game_over_r;
    assign bus.winner        = winner_r;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl with NP=2, NUM_Q=8, SCORE_MAX=5, HOLD_CYC=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_quiz_round_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    quiz_round_ctrl_if #(.NUM_PLAYERS(2), .NUM_Q(8), .SCORE_MAX(5)) bus ();

    quiz_round_ctrl #(
        .NUM_PLAYERS (2),
        .NUM_Q       (8),
        .SCORE_MAX   (5),
        .HOLD_CYC    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Score bus value for two 3-bit player scores.
    function automatic logic [31:0] sc(input int p1, input int p0);
        return 32'(p1 * 8 + p0);
    endfunction

    // Drive a press, then release once the FSM has acted on it (edge k+2).
    task automatic press(input logic [7:0] j);
        bus.joy_n = j;
        step(3);
        bus.joy_n = 8'hFF;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_score"}, 32'(bus.score), 0);
        chk({tag, "_qidx"}, 32'(bus.q_idx), 0);
        chk({tag, "_lock"}, 32'(bus.lockout), 0);
        chk({tag, "_pulse"}, 32'(bus.correct_pulse), 0);
        chk({tag, "_over"}, 32'(bus.game_over), 0);
        chk({tag, "_win"}, 32'(bus.winner), 0);
    endtask

    initial begin
        bus.joy_n = 8'hFF;
        bus.q_ans = 3'd0;
        step(2);
        chk_all_zero("reset");
        rst_n = 1'b1;
        step(4);

        // Q0: P0 correct, latency and RESULT dwell
        bus.q_ans = 3'd3;
        bus.joy_n = 8'hFB;
        step(2);
        chk("q0_latency_score", 32'(bus.score), sc(0, 0));
        step(1);
        chk("q0_score", 32'(bus.score), sc(0, 1));
        chk("q0_pulse", 32'(bus.correct_pulse), 32'h1);
        bus.joy_n = 8'hFF;
        step(1);
        chk("q0_pulse_off", 32'(bus.correct_pulse), 32'h0);
        step(2);
        chk("q0_dwell_qidx", 32'(bus.q_idx), 0);
        step(1);
        chk("q0_next_qidx", 32'(bus.q_idx), 1);
        step(1);

        // Q1: simultaneous presses, lowest index wins
        bus.q_ans = 3'd2;
        press(8'hDD);
        chk("q1_score", 32'(bus.score), sc(0, 2));
        chk("q1_pulse", 32'(bus.correct_pulse), 32'h1);
        step(4);
        chk("q1_qidx", 32'(bus.q_idx), 2);
        step(1);

        // Q2: P0 wrong and locked, its retry ignored, P1 scores
        bus.q_ans = 3'd4;
        press(8'hFE);
        chk("q2_lock", 32'(bus.lockout), 32'h1);
        chk("q2_wrong_score", 32'(bus.score), sc(0, 2));
        step(2);
        press(8'hF7);
        chk("q2_locked_pulse", 32'(bus.correct_pulse), 32'h0);
        chk("q2_locked_score", 32'(bus.score), sc(0, 2));
        chk("q2_locked_lock", 32'(bus.lockout), 32'h1);
        step(2);
        press(8'h7F);
        chk("q2_p1_score", 32'(bus.score), sc(1, 2));
        chk("q2_p1_pulse", 32'(bus.correct_pulse), 32'h2);
        step(4);
        chk("q2_qidx", 32'(bus.q_idx), 3);
        chk("q2_lock_clr", 32'(bus.lockout), 32'h0);
        step(1);

        // Q3: both wrong; same-edge P1 press is discarded, then P1 locks too
        bus.q_ans = 3'd1;
        press(8'hBB);
        chk("q3_lock_p0", 32'(bus.lockout), 32'h1);
        step(2);
        press(8'hBF);
        chk("q3_lock_all", 32'(bus.lockout), 32'h3);
        chk("q3_score", 32'(bus.score), sc(1, 2));
        step(4);
        chk("q3_qidx", 32'(bus.q_idx), 4);
        chk("q3_lock_clr", 32'(bus.lockout), 32'h0);
        step(1);

        // Q4..Q6 drive towards a 3-3 tie
        bus.q_ans = 3'd1;
        press(8'hFE);
        chk("q4_score", 32'(bus.score), sc(1, 3));
        step(5);
        bus.q_ans = 3'd2;
        press(8'hDF);
        chk("q5_score", 32'(bus.score), sc(2, 3));
        step(5);
        bus.q_ans = 3'd3;
        press(8'hBF);
        chk("q6_score", 32'(bus.score), sc(3, 3));
        step(4);
        chk("q6_qidx", 32'(bus.q_idx), 7);
        chk("q6_not_over", 32'(bus.game_over), 0);
        step(1);

        // Q7: last question, both wrong -> tie ends the game
        bus.q_ans = 3'd4;
        press(8'hEE);
        chk("q7_lock_p0", 32'(bus.lockout), 32'h1);
        step(2);
        press(8'hEF);
        chk("q7_lock_all", 32'(bus.lockout), 32'h3);
        step(4);
        chk("q7_over", 32'(bus.game_over), 1);
        chk("q7_winner", 32'(bus.winner), 32'h3);
        chk("q7_qidx", 32'(bus.q_idx), 7);
        chk("q7_score", 32'(bus.score), sc(3, 3));

        // DONE holds regardless of presses
        bus.q_ans = 3'd1;
        press(8'hFE);
        step(3);
        chk("done_score", 32'(bus.score), sc(3, 3));
        chk("done_over", 32'(bus.game_over), 1);
        chk("done_qidx", 32'(bus.q_idx), 7);

        // Game 2: reset mid-RESULT with P0 still holding a button
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(4);
        bus.q_ans = 3'd1;
        bus.joy_n = 8'hFE;
        step(3);
        chk("g2_pre_score", 32'(bus.score), sc(0, 1));
        step(1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("g2_async_rst");
        step(1);
        rst_n = 1'b1;
        bus.q_ans = 3'd2;
        step(8);
        chk("g2_held_lock", 32'(bus.lockout), 32'h0);
        chk("g2_held_score", 32'(bus.score), sc(0, 0));
        bus.joy_n = 8'hFF;
        step(3);
        press(8'hFE);
        chk("g2_repress_lock", 32'(bus.lockout), 32'h1);
        step(2);
        press(8'hDF);
        chk("g2_q0_score", 32'(bus.score), sc(1, 0));
        chk("g2_q0_pulse", 32'(bus.correct_pulse), 32'h2);
        step(5);

        // P1 runs to SCORE_MAX at q_idx 4
        for (int i = 2; i <= 5; i++) begin
            press(8'hDF);
            chk("g2_score", 32'(bus.score), sc(i, 0));
            step(4);
            chk("g2_qidx", 32'(bus.q_idx), (i < 5) ? 32'(i) : 32'd4);
            chk("g2_over", 32'(bus.game_over), (i == 5) ? 32'd1 : 32'd0);
            step(1);
        end
        chk("g2_winner", 32'(bus.winner), 32'h2);
        press(8'hDF);
        step(2);
        chk("g2_sat_score", 32'(bus.score), sc(5, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quiz_round_ctrl.md
QUIZ_ROUND_CTRL -- requirements
Module: quiz_round_ctrl

Interface
REQ-001 Parameter NUM_PLAYERS, default 2: number of player joysticks, range 2..8.
REQ-002 Parameter NUM_Q, default 8: questions per game, range 2..16.
REQ-003 Parameter SCORE_MAX, default 5: score that ends the game immediately, range 1..7.
REQ-004 Parameter HOLD_CYC, default 4: RESULT dwell in clocks, at least 1.
REQ-005 Derived widths: QW = max(1, clog2(NUM_Q)); SW = clog2(SCORE_MAX+1).
REQ-006 clk  in  1  single clock; all state changes occur on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 joy_n  in  4*NUM_PLAYERS  raw active-low buttons; player p occupies bits [4p+3:4p].
REQ-009 q_ans  in  3  correct choice (1..4) for the question at q_idx; held stable by an external question ROM.
REQ-010 q_idx  out  QW  current question index.
REQ-011 score  out  SW*NUM_PLAYERS  per-player score; player p occupies slice p.
REQ-012 correct_pulse  out  NUM_PLAYERS  one-clock pulse on the player credited with a point.
REQ-013 lockout  out  NUM_PLAYERS  players barred from the current question.
REQ-014 game_over  out  1  high in DONE.
REQ-015 winner  out  NUM_PLAYERS  players holding the maximum score; valid while game_over is high.

Function
REQ-016 Each joy_n nibble passes through a 2-flop synchronizer before any use.
REQ-017 Decode per player on the synchronized nibble: 1110->1, 1101->2, 1011->3, 0111->4; every other pattern, including multiple buttons low, decodes to 0 (no press).
REQ-018 A press event is a transition of the decoded choice from 0 to nonzero; a held button produces no further events.
REQ-019 FSM states: RELEASE, ASK, RESULT, DONE.
REQ-020 RELEASE: go to ASK on the first clock on which every decoded choice is 0.
REQ-021 ASK, arbitration: among same-cycle events from non-locked players, the lowest player index wins; all other events that cycle are discarded.
REQ-022 ASK, correct answer (choice == q_ans): increment the winner's score and pulse its correct_pulse bit on the same edge, then go to RESULT.
REQ-023 ASK, wrong answer: set the winner's lockout bit and stay in ASK; if all bits are then set, go to RESULT with no score change.
REQ-024 ASK, events from locked players are ignored.
REQ-025 RESULT: remain HOLD_CYC clocks. Then:
- go to DONE if q_idx == NUM_Q-1 or any score == SCORE_MAX;
- otherwise increment q_idx, clear lockout and go to RELEASE.
REQ-026 DONE: register winner as the bitmask of all players whose score equals the maximum (ties set multiple bits); hold every output until reset.
REQ-027 Latency: a correct press applied to joy_n before edge k is visible on score and correct_pulse after edge k+2.
REQ-028 Scores never exceed SCORE_MAX and never wrap; q_idx never exceeds NUM_Q-1.

Reset
REQ-029 Asserting rst_n low, in any state and at any time, immediately clears all of the following:
- synchronizers and the previous-choice registers;
- score, q_idx, lockout, correct_pulse, winner and game_over;
- the FSM, which is forced to RELEASE.
REQ-030 After rst_n deasserts, any button still held produces no event until it has been released.

Structure
REQ-031 The shared package quiz_pkg shall hold the FSM state enum, the decode function or table, and the choice width constant (3).
REQ-032 Sub-module quiz_joy_decode shall contain one player's synchronizer, decoder and press-edge detector; it is instantiated NUM_PLAYERS times.

Verification
REQ-033 NP=2, q_ans=3: P0 applies 1011 -> P0 score 0->1 after edge k+2; correct_pulse=01 for one clock; RESULT lasts 4 clocks; q_idx becomes 1.
REQ-034 NP=2, q_ans=2: P1 and P0 press 1101 on the same edge -> only P0 is credited; P1 score is unchanged.
REQ-035 q_ans=4: P0 presses 1110 -> lockout=01 and the FSM stays in ASK; P0 then presses 0111 -> ignored; P1 presses 0111 -> P1 score +1.
REQ-036 NP=2, both players answer wrong -> lockout=11, RESULT is entered, no score change, q_idx advances.
REQ-037 SCORE_MAX=5: P1 reaches 5 at q_idx=4 -> game_over=1, winner=10, q_idx holds 4; NUM_Q=8 with a 3-3 tie at the end -> winner=11.
REQ-038 rst_n pulsed low mid-RESULT with joy_n=1110 held -> all outputs 0 and no event until P0 releases and presses again.
